// File: rtl/serial_pkg.sv
// Shared definitions for the serial work-loading path: bit-period helper,
// byte receiver state encoding and the default work frame length.
package serial_pkg;

  // Default getwork frame: 76-byte header, 4-byte nonce, 4-byte target.
  localparam int WORK_FRAME_BYTES = 84;

  // Byte receiver states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int bit_cycles(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop input synchroniser, byte FSM and bit-period
// counter. Exposes its FSM state on the state output.
//
// Strobe semantics: byte_valid and stop_err are single-cycle strobes with no
// ready/back-pressure. byte_data is the value to take in the byte_valid
// cycle; the consumer must capture it then. They are decoded in the stop
// sample cycle, so a registered consumer updates on the following cycle.
module uart_rx_byte
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output rx_state_t  state
);

  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

  logic             rxd_meta_q;
  logic             rxd_s_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  // Next-state, sample timing and strobe decode for the byte FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A line already back high at mid start bit is a glitch.
          state_d   = rxd_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // Return to IDLE straight away so a start bit following the
          // stop sample with no idle time is still caught.
          state_d = IDLE;
          if (rxd_s_q) begin
            byte_valid = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser and FSM registers; the line idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  assign byte_data = shift_q;
  assign state     = state_q;

endmodule

// File: rtl/serial_work_rx.sv
// Work frame receiver: assembles NUM_BYTES serial bytes into a frame and
// publishes it on work_data with a one-cycle rx_done strobe.
// Optional build macro SERIAL_WORK_RX_TIMEOUT_EN: an idle gap of
// TIMEOUT_BITS bit periods discards a partial frame so the next byte starts
// a fresh frame. Without it a partial frame is held until reset.
module serial_work_rx
  import serial_pkg::*;
#(
  parameter int comm_clk_frequency = 100_000_000,
  parameter int baud_rate          = 115_200,
  parameter int NUM_BYTES          = WORK_FRAME_BYTES,
  parameter int TIMEOUT_BITS       = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxd,
  output logic [8*NUM_BYTES-1:0] work_data,
  output logic                   rx_done,
  output logic                   frame_err,
  output logic [6:0]             byte_count
);

  localparam int BIT_CYCLES = bit_cycles(comm_clk_frequency, baud_rate);
  localparam int FW         = 8 * NUM_BYTES;
  localparam logic [6:0] LAST_IDX = 7'(NUM_BYTES - 1);

  generate
    if (BIT_CYCLES < 4 || TIMEOUT_BITS < 1 || NUM_BYTES < 2 || NUM_BYTES > 128) begin : g_bad_cfg
      $error("serial_work_rx: BIT_CYCLES must be >= 4, TIMEOUT_BITS >= 1, NUM_BYTES 2..128");
    end
  endgenerate

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       stop_err;
  rx_state_t  rx_state;

  uart_rx_byte #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err),
    .state      (rx_state)
  );

  logic [FW-1:0] frame_q, frame_d;
  logic [FW-1:0] work_q, work_d;
  logic [6:0]    count_q, count_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_hit;

`ifdef SERIAL_WORK_RX_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            idle_run;

  // Idle gap counter: only meaningful while a partial frame is pending.
  always_comb begin
    idle_run    = (rx_state == IDLE) && (count_q != 7'd0);
    timeout_hit = idle_run && (idle_q == TO_W'(TO_CYCLES - 1));
    idle_d      = '0;
    if (idle_run && !timeout_hit) begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_rx_state;
  assign unused_rx_state = ^rx_state;
  assign timeout_hit     = 1'b0;
`endif

  // Frame assembly: shift in accepted bytes, publish on the last one.
  always_comb begin
    frame_d     = frame_q;
    work_d      = work_q;
    count_d     = count_q;
    rx_done_d   = 1'b0;
    frame_err_d = stop_err;
    if (byte_valid) begin
      frame_d = {frame_q[FW-9:0], byte_data};
      if (count_q == LAST_IDX) begin
        work_d    = frame_d;
        count_d   = 7'd0;
        rx_done_d = 1'b1;
      end else begin
        count_d = count_q + 7'd1;
      end
    end else if (timeout_hit) begin
      frame_d = '0;
      count_d = 7'd0;
    end
  end

  // Frame, holding and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= '0;
      work_q      <= '0;
      count_q     <= 7'd0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      work_q      <= work_d;
      count_q     <= count_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign work_data  = work_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_serial_work_rx.sv
// Directed bench for serial_work_rx at 1 MHz / 115200 baud (9 cycles/bit).
module tb_serial_work_rx;

  localparam int FREQ = 1_000_000;
  localparam int BAUD = 115_200;
  localparam int NB   = 84;
  localparam int BC   = 9;
  localparam int W    = 8 * NB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         rxd   = 1'b1;
  logic [W-1:0] work_data;
  logic         rx_done;
  logic         frame_err;
  logic [6:0]   byte_count;

  int n_cmp    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int exp_done = 0;
  int exp_cnt  = 0;
  int base_done;

  logic [W-1:0] exp_wd = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_frame;

  serial_work_rx #(
    .comm_clk_frequency (FREQ),
    .baud_rate          (BAUD),
    .NUM_BYTES          (NB),
    .TIMEOUT_BITS       (40)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .work_data  (work_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .byte_count (byte_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_done must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done || frame_err) check("strobe_excl", W'(rx_done & frame_err), '0);
      if (rx_done) begin
        done_cnt++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_done: observed rx_done with no frame pending, expected none");
        end
        if (exp_q.size() != 0) check("frame_data", work_data, exp_q.pop_front());
      end
      if (frame_err) err_cnt++;
    end
  end

  // Reference model for one accepted byte.
  task automatic model_byte(input logic [7:0] d);
    exp_wd = {exp_wd[W-9:0], d};
    exp_cnt++;
    if (exp_cnt == NB) begin
      exp_q.push_back(exp_wd);
      last_frame = exp_wd;
      exp_cnt    = 0;
      exp_done++;
    end
  endtask

  // Driver: one bit period, changes at the falling edge.
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_good(input logic [7:0] d);
    model_byte(d);
    send_byte(d, 1'b1);
    check("byte_count", W'(byte_count), W'(exp_cnt));
    check("done_count", W'(done_cnt), W'(exp_done));
  endtask

  // Work frame: 000007ff0000318e ... 01000000
  function automatic logic [7:0] frame_byte(input int i);
    logic [63:0] head;
    logic [31:0] tail;
    head = 64'h0000_07ff_0000_318e;
    tail = 32'h0100_0000;
    if (i < 8) return head[8*(7-i) +: 8];
    if (i >= 80) return tail[8*(83-i) +: 8];
    return 8'((i * 29 + 3) & 255);
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_work_data", work_data, '0);
    check("rst_rx_done", W'(rx_done), '0);
    check("rst_frame_err", W'(frame_err), '0);
    check("rst_byte_count", W'(byte_count), '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte 0xA5: count changes exactly on the cycle after the stop sample
    model_byte(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (87) @(negedge clk);
        check("a5_count_before", W'(byte_count), W'(0));
        @(negedge clk);
        check("a5_count_after", W'(byte_count), W'(1));
      end
    join
    check("a5_no_done", W'(done_cnt), W'(0));

    // Low stop bit: one frame_err, byte dropped
    send_byte(8'h5A, 1'b0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_count", W'(err_cnt), W'(1));
    check("ferr_byte_count", W'(byte_count), W'(1));

    // Next good byte accepted normally
    send_good(8'h3C);

    // Three-cycle glitch: nothing received
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_byte_count", W'(byte_count), W'(2));
    check("glitch_no_ferr", W'(err_cnt), W'(1));

    // Complete the first frame: A5, 3C, then 82 pattern bytes
    for (int i = 0; i < 82; i++) send_good(8'((i * 7 + 1) & 255));
    repeat (5) @(negedge clk);
    check("frame1_done", W'(done_cnt), W'(1));

    // Reference work frame back-to-back
    for (int i = 0; i < NB; i++) send_good(frame_byte(i));
    repeat (5) @(negedge clk);
    check("frame2_done", W'(done_cnt), W'(2));
    check("frame2_first_byte", W'(work_data[671:664]), W'(8'h00));
    check("frame2_byte3", W'(work_data[647:640]), W'(8'hff));
    check("frame2_last_byte", W'(work_data[7:0]), W'(8'h00));
    check("frame2_byte80", W'(work_data[31:24]), W'(8'h01));
    check("frame2_word", work_data, last_frame);
    check("frame2_count", W'(byte_count), W'(0));

    // 40 bytes, then reset in the middle of the 41st
    for (int i = 0; i < 40; i++) send_good(8'($urandom_range(0, 255)));
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_count", W'(byte_count), W'(0));
    check("midrst_work_data", work_data, '0);
    exp_wd  = '0;
    exp_cnt = 0;
    rst_n   = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      send_good(8'((i * 13 + 100) & 255));
      if (i == 20) check("hold_stable", work_data, '0);
    end
    repeat (5) @(negedge clk);
    check("post_rst_done", W'(done_cnt), W'(3));

    // Ten bytes, long idle gap, then a full frame
    for (int i = 0; i < 10; i++) send_good(8'(i + 200));
    rxd = 1'b1;
    repeat (40 * BC + 1) @(negedge clk);
`ifdef SERIAL_WORK_RX_TIMEOUT_EN
    check("timeout_cleared", W'(byte_count), W'(0));
    exp_wd  = '0;
    exp_cnt = 0;
`else
    check("partial_held", W'(byte_count), W'(10));
`endif
    base_done = done_cnt;
    for (int i = 0; i < NB; i++) begin
      send_good(8'((i * 3 + 17) & 255));
`ifdef SERIAL_WORK_RX_TIMEOUT_EN
      if (i == 73) check("to_no_early_done", W'(done_cnt), W'(base_done));
`else
      if (i == 72) check("held_before_74", W'(done_cnt), W'(base_done));
      if (i == 73) check("held_done_at_74", W'(done_cnt), W'(base_done + 1));
`endif
    end
    repeat (5) @(negedge clk);
    check("gap_total_done", W'(done_cnt), W'(base_done + 1));
`ifdef SERIAL_WORK_RX_TIMEOUT_EN
    check("gap_final_count", W'(byte_count), W'(0));
`else
    check("gap_final_count", W'(byte_count), W'(10));
`endif
    check("no_pending_frames", W'(exp_q.size()), W'(0));
    check("total_ferr", W'(err_cnt), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
